// File: rtl/vec_mode_unit.sv
// rtl/vec_mode_unit.sv - handshaked lane-wise vector transform unit (optional rotate modes: VEC_MODE_ROTATE_EN)
module vec_mode_unit #(
   parameter int LANES = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_mode,
   input  logic [WIDTH-1:0]         in_key,
   input  logic [LANES*WIDTH-1:0]   in_a,
   input  logic [LANES*WIDTH-1:0]   in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   out_data,
   output logic                     out_err,
   output logic                     busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [2:0] MODE_MUL = 3'd5;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                   accept;
   logic [LANES*WIDTH-1:0] a_q, b_q, acc_q;
   logic [SHW-1:0]         cnt_q;
   logic [LANES*WIDTH-1:0] single_res;
   logic                   single_err;
   logic [LANES*WIDTH-1:0] mul_next;

   // One lane of a single-cycle mode; MSB of the return value flags an illegal mode.
   function automatic logic [WIDTH:0] lane_op(input logic [2:0] mode,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] key);
      logic [SHW-1:0]     sh;
      logic [2*WIDTH-1:0] dbl;
      sh  = key[SHW-1:0];
      dbl = {a, a};
      lane_op = {1'b1, a};
      case (mode)
         3'd0: lane_op = {1'b0, a ^ b};
         3'd1: lane_op = {1'b0, a >> sh};
         3'd2: lane_op = {1'b0, a << sh};
         3'd3: lane_op = {1'b0, a + key};
         3'd4: lane_op = {1'b0, a - key};
         3'd5: lane_op = {1'b0, a};
`ifdef VEC_MODE_ROTATE_EN
         3'd6: begin
            dbl = dbl >> sh;
            lane_op = {1'b0, dbl[WIDTH-1:0]};
         end
         3'd7: begin
            dbl = dbl << sh;
            lane_op = {1'b0, dbl[2*WIDTH-1:WIDTH]};
         end
`endif
         default: lane_op = {1'b1, a};
      endcase
   endfunction

   // Single-cycle result computed straight from the incoming operands so it can be registered on the accept edge.
   always_comb begin
      logic [WIDTH:0] r;
      single_res = '0;
      single_err = 1'b0;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         r = lane_op(in_mode, in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH], in_key);
         single_res[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
         single_err = single_err | r[WIDTH];
      end
   end

   // One shift-add step per lane: add a<<cnt when bit cnt of b is set, truncated to the lane.
   always_comb begin
      mul_next = '0;
      for (int i = 0; i < LANES; i++) begin
         if (b_q[i*WIDTH + int'(cnt_q)])
            mul_next[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH] + (a_q[i*WIDTH +: WIDTH] << cnt_q);
         else
            mul_next[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and handshake outputs; a result leaving DONE can be replaced by a new accept in the same cycle.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_d = (in_mode == MODE_MUL) ? MUL : DONE;
         end
         MUL: begin
            if (cnt_q == CNT_LAST)
               state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid)
                  state_d = (in_mode == MODE_MUL) ? MUL : DONE;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Operand capture, multiply iteration and result registers; results only move on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else if (accept) begin
         a_q   <= in_a;
         b_q   <= in_b;
         acc_q <= '0;
         cnt_q <= '0;
         if (in_mode != MODE_MUL) begin
            out_data <= single_res;
            out_err  <= single_err;
         end
      end else if (state_q == MUL) begin
         acc_q <= mul_next;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            out_data <= mul_next;
            out_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vec_mode_unit.sv
// tb/tb_vec_mode_unit.sv - directed-vector bench for vec_mode_unit
module tb_vec_mode_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_mode;
   logic [7:0]  in_key;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   vec_mode_unit #(.LANES(4), .WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_key    (in_key),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] mode, input logic [7:0] key,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_mode  = mode;
      in_key   = key;
      in_a     = a;
      in_b     = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [31:0] held;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_mode = 3'd0; in_key = 8'h00; in_a = '0; in_b = '0;
      tick(); tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_out_data",  out_data,           32'd0);
      check("rst_out_err",   {31'b0, out_err},   32'd0);
      reset = 1'b0;
      tick();

      // reset three cycles into a multiply
      drive(3'd5, 8'h00, 32'h0203_1010, 32'h0304_1011);
      tick();
      in_valid = 1'b0;
      check("mul_busy", {31'b0, busy}, 32'd1);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_busy",      {31'b0, busy},      32'd0);
      check("abort_in_ready",  {31'b0, in_ready},  32'd1);
      out_ready = 1'b1;
      drive(3'd0, 8'h00, 32'h1234_5678, 32'h00FF_FF00);
      tick();
      in_valid = 1'b0;
      check("post_abort_valid", {31'b0, out_valid}, 32'd1);
      check("post_abort_xor",   out_data,           32'h12CB_A978);
      tick();
      check("post_abort_idle",  {31'b0, out_valid}, 32'd0);

      // xor then lshift back to back
      drive(3'd0, 8'h00, 32'h0F0F_F0F0, 32'hFFFF_FFFF);
      tick();
      check("xor_valid",   {31'b0, out_valid}, 32'd1);
      check("xor_data",    out_data,           32'hF0F0_0F0F);
      check("xor_ready",   {31'b0, in_ready},  32'd1);
      drive(3'd2, 8'h09, 32'h8101_4003, 32'h0000_0000);
      tick();
      in_valid = 1'b0;
      check("lsh_valid",   {31'b0, out_valid}, 32'd1);
      check("lsh_data",    out_data,           32'h0202_8006);
      tick();
      check("b2b_idle",    {31'b0, out_valid}, 32'd0);

      // rshift by maximum amount
      drive(3'd1, 8'h0F, 32'h80FF_0102, 32'h0000_0000);
      tick();
      in_valid = 1'b0;
      check("rsh_data", out_data, 32'h0101_0000);
      tick();

      // ecae / dcae wrap
      drive(3'd3, 8'h01, 32'hFF00_7F80, 32'h0);
      tick();
      check("ecae_data", out_data,         32'h0001_8081);
      check("ecae_err",  {31'b0, out_err}, 32'd0);
      drive(3'd4, 8'h01, 32'h0001_8081, 32'h0);
      tick();
      in_valid = 1'b0;
      check("dcae_data", out_data, 32'hFF00_7F80);
      tick();

      // multiply with backpressure
      out_ready = 1'b0;
      drive(3'd5, 8'h00, 32'h0203_1010, 32'h0304_1011);
      tick();
      in_valid = 1'b0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (out_valid) begin
            k = c;
            break;
         end
      end
      check("mul_latency", k, 32'd8);
      check("mul_data", out_data, 32'h060C_0010);
      check("mul_err", {31'b0, out_err}, 32'd0);
      held = 32'h060C_0010;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_valid", {31'b0, out_valid}, 32'd1);
         check("bp_data",  out_data,           held);
         check("bp_ready", {31'b0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("mul_drain", {31'b0, out_valid}, 32'd0);

      // modes 6 and 7
      drive(3'd6, 8'h01, 32'h0102_0381, 32'h0);
      tick();
`ifdef VEC_MODE_ROTATE_EN
      check("m6_data", out_data,         32'h8001_81C0);
      check("m6_err",  {31'b0, out_err}, 32'd0);
`else
      check("m6_data", out_data,         32'h0102_0381);
      check("m6_err",  {31'b0, out_err}, 32'd1);
`endif
      drive(3'd7, 8'h01, 32'h0102_0381, 32'h0);
      tick();
      in_valid = 1'b0;
`ifdef VEC_MODE_ROTATE_EN
      check("m7_data", out_data,         32'h0204_0603);
      check("m7_err",  {31'b0, out_err}, 32'd0);
`else
      check("m7_data", out_data,         32'h0102_0381);
      check("m7_err",  {31'b0, out_err}, 32'd1);
`endif
      tick();
      check("final_idle", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
